// File: rtl/led_pattern_player_pkg.sv
// Shared types and entry field positions for the LED pattern player.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package led_pattern_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Wide enough to count the extra BRAM read cycles (at most two)
    localparam int WAIT_CNT_W = 2;

    // Pattern occupies the low NUM_LEDS bits of an entry
    function automatic int pat_msb(input int num_leds);
        return num_leds - 1;
    endfunction

    // Hold count sits between the pattern and the last flag
    function automatic int hold_lsb(input int num_leds);
        return num_leds;
    endfunction

    function automatic int hold_msb(input int data_width);
        return data_width - 2;
    endfunction

    function automatic int hold_width(input int data_width, input int num_leds);
        return data_width - 1 - num_leds;
    endfunction

    // Top bit marks the final entry of a pattern list
    function automatic int last_bit(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/bram_port_if.sv
// Read/write BRAM port bundle (address, write enable, write data, read data).
// Latency: set by the attached memory, not by this bundle.
// Backpressure: none; the memory always accepts an address.
interface bram_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output we, output addr, output din, input dout);
    modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/led_hold_counter.sv
// Down-counter that times how long one LED pattern stays on the outputs.
// Latency: load/decrement take effect on the next clock; done is registered state.
// Backpressure: none; decrement at zero is ignored.
module led_hold_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority over decrement; never wrap below zero
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/led_pattern_player.sv
// Plays a list of {pattern, hold, last} entries from BRAM onto the LED outputs.
// Latency: each entry is shown for max(H,1)+1+READ_LATENCY cycles; first FETCH one cycle after enable.
// Backpressure: none; dropping i_enable returns to IDLE next clock and discards any in-flight read.
module led_pattern_player
    import led_pattern_player_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_LEDS     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic [NUM_LEDS-1:0]   o_leds,
    output logic                  o_busy,
    output logic                  o_wrap,
    bram_port_if.master           bram_port
);

    localparam int PAT_MSB  = pat_msb(NUM_LEDS);
    localparam int HOLD_LSB = hold_lsb(NUM_LEDS);
    localparam int HOLD_MSB = hold_msb(DATA_WIDTH);
    localparam int HOLD_W   = hold_width(DATA_WIDTH, NUM_LEDS);
    localparam int LAST_BIT = last_bit(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_LEDS-1:0]     leds_q, leds_d;
    logic                    last_q, last_d;
    logic                    load_pend_q, load_pend_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [HOLD_W-1:0]       dout_hold;
    logic [HOLD_W-1:0]       hold_load_val;
    logic                    hold_load;
    logic                    hold_dec;
    logic                    hold_done;
    logic                    advance;
    logic                    wrap_now;

    // The first HOLD cycle is the one where dout is valid; it loads rather than counts
    assign dout_hold     = bram_port.dout[HOLD_MSB:HOLD_LSB];
    assign hold_load_val = (dout_hold == '0) ? HOLD_W'(1) : dout_hold;
    assign hold_load     = (state_q == ST_HOLD) && load_pend_q;
    assign hold_dec      = (state_q == ST_HOLD) && !load_pend_q;
    assign advance       = hold_dec && hold_done;
    assign wrap_now      = advance && (last_q || (addr_q == {ADDR_WIDTH{1'b1}}));

    // Read-only port: address follows the address register, which only moves on entry to FETCH
    assign bram_port.we   = 1'b0;
    assign bram_port.din  = '0;
    assign bram_port.addr = addr_q;

    led_hold_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (hold_load),
        .i_load_val (hold_load_val),
        .i_dec      (hold_dec),
        .o_done     (hold_done)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enable low overrides everything and parks in IDLE
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = (READ_LATENCY == 1) ? ST_HOLD : ST_WAIT;
                ST_WAIT:  state_d = (wait_cnt_q == '0) ? ST_HOLD : ST_WAIT;
                ST_HOLD:  state_d = advance ? ST_FETCH : ST_HOLD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        o_busy = (state_q != ST_IDLE);
        o_wrap = wrap_now;
        o_leds = leds_q;
    end

    // Datapath next values: address sequencing, wait count, pattern capture
    always_comb begin
        addr_d      = addr_q;
        leds_d      = leds_q;
        last_d      = last_q;
        load_pend_d = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        if (!i_enable) begin
            leds_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = i_base_addr;
                end
                ST_FETCH: begin
                    if (READ_LATENCY == 1) begin
                        load_pend_d = 1'b1;
                    end else begin
                        wait_cnt_d = WAIT_CNT_W'(READ_LATENCY - 2);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        load_pend_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (load_pend_q) begin
                        leds_d = bram_port.dout[PAT_MSB:0];
                        last_d = bram_port.dout[LAST_BIT];
                    end else if (advance) begin
                        addr_d = wrap_now ? i_base_addr : (addr_q + 1'b1);
                    end
                end
                default: begin
                    addr_d = addr_q;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q      <= '0;
            leds_q      <= '0;
            last_q      <= 1'b0;
            load_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            leds_q      <= leds_d;
            last_q      <= last_d;
            load_pend_q <= load_pend_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_player.sv
// Bench for led_pattern_player: two instances (read latency 1 and 3) on one shared memory image.
// Latency: reference model tracks each entry by cycle position within its display period.
// Backpressure: not applicable.
module tb_led_pattern_player;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic [AW-1:0] base1, base3;
    logic [NL-1:0] leds1, leds3;
    logic          busy1, busy3, wrap1, wrap3;
    logic [DW-1:0] mem [16];

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;

    bram_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bp1 ();
    bram_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bp3 ();

    led_pattern_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LEDS(NL), .READ_LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_base_addr(base1),
        .o_leds(leds1), .o_busy(busy1), .o_wrap(wrap1), .bram_port(bp1));

    led_pattern_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LEDS(NL), .READ_LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_base_addr(base3),
        .o_leds(leds3), .o_busy(busy3), .o_wrap(wrap3), .bram_port(bp3));

    // Synchronous-read memories with 1 and 3 cycles of read latency
    logic [DW-1:0] r1, s1, s2, s3;
    always @(posedge clk) r1 <= mem[bp1.addr];
    always @(posedge clk) begin
        s1 <= mem[bp3.addr];
        s2 <= s1;
        s3 <= s2;
    end
    assign bp1.dout = r1;
    assign bp3.dout = s3;

    function automatic logic [DW-1:0] ent(input int pat, input int hold, input bit last);
        logic [DW-1:0] e;
        e = {last, 11'(hold), 4'(pat)};
        return e;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit            active;
        int            a;
        int            t;
        logic [NL-1:0] leds;
    } mdl_t;

    mdl_t mdl [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int period(input int k, input int a);
        int h;
        h = int'(mem[a][DW-2:NL]);
        if (h == 0) h = 1;
        return h + lat_of(k) + 1;
    endfunction

    function automatic bit wraps(input int a);
        return mem[a][DW-1] || (a == 15);
    endfunction

    function automatic mdl_t step(input mdl_t m, input int k);
        mdl_t n;
        int   b;
        n = m;
        b = (k == 0) ? int'(base1) : int'(base3);
        if (!en) begin
            n.active = 1'b0;
            n.leds   = '0;
        end else if (!m.active) begin
            n.active = 1'b1;
            n.a      = b;
            n.t      = 0;
        end else begin
            if (m.t == lat_of(k)) n.leds = mem[m.a][NL-1:0];
            n.t = m.t + 1;
            if (n.t == period(k, m.a)) begin
                n.t = 0;
                n.a = wraps(m.a) ? b : m.a + 1;
            end
        end
        return n;
    endfunction

    function automatic int exp_wrap(input int k);
        if (!mdl[k].active) return 0;
        return int'((mdl[k].t == period(k, mdl[k].a) - 1) && wraps(mdl[k].a));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) mdl[k] <= '{1'b0, 0, 0, '0};
        end else begin
            for (int k = 0; k < 2; k++) mdl[k] <= step(mdl[k], k);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle: both instances against the model, and the port never writes
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_leds1", int'(leds1), int'(mdl[0].leds));
            chk("m_busy1", int'(busy1), int'(mdl[0].active));
            chk("m_wrap1", int'(wrap1), exp_wrap(0));
            chk("m_leds3", int'(leds3), int'(mdl[1].leds));
            chk("m_busy3", int'(busy3), int'(mdl[1].active));
            chk("m_wrap3", int'(wrap3), exp_wrap(1));
            chk("we1", int'(bp1.we), 0);
            chk("we3", int'(bp3.we), 0);
        end
    end

    typedef struct {
        logic       en;
        logic [3:0] l1;
        logic       w1;
        logic [3:0] l3;
        logic       w3;
        logic       b;
    } vec_t;

    vec_t vec [16];
    int   r;

    initial begin
        vec[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1};
        vec[5]  = '{1'b1, 4'h5, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 4'h5, 1'b0, 4'h3, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 4'h5, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 4'hA, 1'b1, 4'h3, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 4'hA, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[10] = '{1'b1, 4'hA, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[11] = '{1'b1, 4'h5, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[12] = '{1'b1, 4'h5, 1'b0, 4'h3, 1'b1, 1'b1};
        vec[13] = '{1'b0, 4'h5, 1'b0, 4'h3, 1'b0, 1'b1};
        vec[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vec[15] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        base1 = 4'd0;
        base3 = 4'd4;
        for (int j = 0; j < 16; j++) mem[j] = '0;
        mem[0] = ent(5, 3, 1'b0);
        mem[1] = ent(10, 0, 1'b1);
        mem[4] = ent(3, 2, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_leds1", int'(leds1), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_wrap1", int'(wrap1), 0);
        chk("rst_addr1", int'(bp1.addr), 0);
        chk("rst_leds3", int'(leds3), 0);
        chk("rst_busy3", int'(busy3), 0);
        chk("rst_addr3", int'(bp3.addr), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Two-entry list at latency 1, single looping entry at latency 3
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_leds1", i), int'(leds1), int'(vec[i].l1));
            chk($sformatf("vec%0d_wrap1", i), int'(wrap1), int'(vec[i].w1));
            chk($sformatf("vec%0d_leds3", i), int'(leds3), int'(vec[i].l3));
            chk($sformatf("vec%0d_wrap3", i), int'(wrap3), int'(vec[i].w3));
            chk($sformatf("vec%0d_busy", i), int'(busy1 & busy3), int'(vec[i].b));
            #1 en = vec[i].en;
        end

        // Top address without last flag wraps; base change mid-run applies only at the wrap
        #1 base1 = 4'd15;
        mem[15] = ent(9, 1, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("top_fetch_addr", int'(bp1.addr), 15);
        #1 base1 = 4'd2;
        @(negedge clk);
        chk("top_hold_addr", int'(bp1.addr), 15);
        @(negedge clk);
        chk("top_wrap", int'(wrap1), 1);
        chk("top_leds", int'(leds1), 9);
        @(negedge clk);
        chk("top_new_base", int'(bp1.addr), 2);
        chk("top_wrap_once", int'(wrap1), 0);
        #1 en = 1'b0;
        base1 = 4'd0;
        repeat (2) @(negedge clk);

        // Enable dropped while the latency-3 instance waits on its read
        #1 en = 1'b1;
        repeat (8) @(negedge clk);
        chk("wait_busy", int'(busy3), 1);
        chk("wait_leds", int'(leds3), 3);
        #1 en = 1'b0;
        @(negedge clk);
        chk("drop_leds", int'(leds3), 0);
        chk("drop_busy", int'(busy3), 0);
        #1 en = 1'b1;
        @(negedge clk);
        chk("restart_busy", int'(busy3), 1);
        chk("restart_addr", int'(bp3.addr), 4);
        chk("late_dout_leds", int'(leds3), 0);
        @(negedge clk);
        chk("late_dout_leds2", int'(leds3), 0);
        repeat (3) @(negedge clk);
        chk("restart_leds", int'(leds3), 3);

        // Reset pulsed in the middle of a hold
        #1 en = 1'b0;
        repeat (2) @(negedge clk);
        #1 en = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_leds", int'(leds1), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_leds1", int'(leds1), 0);
        chk("async_busy1", int'(busy1), 0);
        chk("async_wrap1", int'(wrap1), 0);
        chk("async_leds3", int'(leds3), 0);
        chk("async_busy3", int'(busy3), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy1), 1);
        chk("post_rst_addr", int'(bp1.addr), 0);
        chk("post_rst_leds", int'(leds1), 0);
        @(negedge clk);
        chk("post_rst_leds2", int'(leds1), 0);
        @(negedge clk);
        chk("post_rst_first", int'(leds1), 5);

        // Randomized lists, bases, enable drops and reset pulses
        for (int seg = 0; seg < 8; seg++) begin
            @(negedge clk);
            #1 en = 1'b0;
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            #1;
            for (int j = 0; j < 16; j++)
                mem[j] = ent($urandom_range(0, 15), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            base1 = 4'($urandom);
            base3 = 4'($urandom);
            en = 1'b1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                #1;
                r = $urandom_range(0, 199);
                en    = (r >= 5);
                rst_n = (r != 100);
                if (r >= 185) base1 = 4'($urandom);
                if (r >= 170 && r < 185) base3 = 4'($urandom);
            end
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
